muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit that owns the CPU's HI and LO registers. It is the producer side of the Hi/Lo interface: the ALU and the datapath issue MULT/MULTU/DIV/DIVU to it and read the two result halves back through an mfhi/mflo read port. It replaces single-cycle `*` and `/` with a shift-add / restoring-divide sequence, using a start/busy/done handshake that the controller stalls on.

## Interface
- N, 32: operand and HI/LO width; must be even and ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled on clk only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  N  multiplicand / dividend.
- b  in  N  multiplier / divisor.
- wr_hi, wr_lo  in  1  mthi/mtlo write enables.
- wdata  in  N  mthi/mtlo write data.
- rd_hi  in  1  read select: 1 = HI, 0 = LO.
- rdata  out  N  combinational HI or LO, chosen by rd_hi.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO take a new result.
- div_zero  out  1  sticky flag: last division had b == 0; cleared on the next accepted start.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE with start=1:
  - latch |a| and |b| (two's-complement magnitudes for MULT/DIV; raw values for MULTU/DIVU);
  - record the result sign(s) and clear the iteration counter;
  - go to MUL or DIV. For DIV/DIVU with b == 0, go straight to FIX with div_zero=1.
- MUL: one shift-add step per cycle over a 2N-bit accumulator. Exactly N steps, then FIX.
- DIV: one restoring step per cycle; shift the remainder, trial-subtract, set the quotient bit. Exactly N steps, then FIX.
- FIX: apply signs and write HI/LO; return to IDLE.
  - MULT: negate the 2N-bit product if sign(a) ≠ sign(b). HI = product[2N-1:N], LO = product[N-1:0].
  - DIV: the quotient is negated if sign(a) ≠ sign(b); the remainder takes the sign of a. LO = quotient, HI = remainder.
  - Divide-by-zero: HI = a (unmodified), LO = all ones.
  - 0x80000000 / -1 (signed) wraps: LO = 0x80000000, HI = 0.
- HI/LO change only in FIX, or through mthi/mtlo while IDLE. rdata returns the old values throughout an operation.
- mthi/mtlo are honoured only in IDLE with start=0.
  - A write during busy is dropped.
  - When start and a write occur in the same cycle, start wins and the write is dropped.
  - wr_hi and wr_lo together write wdata to both registers.
- start outside IDLE is ignored; there is no queue.

## Timing
- Reset values: state IDLE; HI=0, LO=0; busy=0; done=0; div_zero=0; rdata=0.
- Start accepted at edge E0: busy=1 from E0 until edge E(N+1).
  - Iterations occur at E1..EN.
  - HI/LO are written at E(N+1); busy drops and done=1 for exactly one cycle after E(N+1).
  - Latency is N+1 cycles, i.e. 33 for N=32.
- Divide-by-zero: HI/LO written at E1; done for one cycle after E1.
- A new start may be accepted in the cycle where done=1, since the FSM is already in IDLE.
- rdata is combinational from HI/LO and rd_hi, with no added latency.
- Reset mid-operation clears everything asynchronously. The partial result is discarded and HI/LO return to 0.

## Structure
- Shared package `muldiv_pkg` holds:
  - the op typedef enum (MULT, MULTU, DIV, DIVU);
  - the state typedef enum (IDLE, MUL, DIV, FIX);
  - a width-generic two's-complement magnitude/negate function.
- No sub-module: a single always_ff FSM/datapath plus a combinational rdata mux. The counter is $clog2(N)+1 bits.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done exactly 33 cycles after start; busy high for 33 cycles.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → done one cycle after start, HI=0x00000064, LO=0xFFFFFFFF, div_zero=1. The next MULTU start clears div_zero.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start a MULT, then pulse start with new operands plus wr_hi (wdata=0xDEADBEEF) at cycle 10. Required: both ignored; the final HI/LO are from the first operation; rdata shows the pre-operation HI/LO until done.
- Assert rst_n=0 at cycle 20 of a DIVU: busy, done and div_zero go to 0 immediately; HI=LO=0. A start after release completes normally in 33 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// MAXW bounds the widest value the negate helpers handle (2N bits).
package muldiv_pkg;

   localparam int MAXW = 64;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIX  = 2'b11
   } state_t;

   // Two's-complement negate of the low w bits of v; upper bits cleared.
   function automatic logic [MAXW-1:0] neg_w(
      input logic [MAXW-1:0] v,
      input int              w
   );
      logic [MAXW-1:0] m;
      if (w >= MAXW) m = '1;
      else m = (MAXW'(1) << w) - MAXW'(1);
      return (~v + MAXW'(1)) & m;
   endfunction

   function automatic logic [MAXW-1:0] mag_w(
      input logic [MAXW-1:0] v,
      input int              w,
      input logic            sgn
   );
      logic msb;
      msb = |(v & (MAXW'(1) << (w - 1)));
      return (sgn && msb) ? neg_w(v, w) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI and LO.
// One step per cycle; signs are stripped on entry and reapplied in FIX.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         wr_hi,
   input  logic         wr_lo,
   input  logic [N-1:0] wdata,
   input  logic         rd_hi,
   output logic [N-1:0] rdata,
   output logic         busy,
   output logic         done,
   output logic         div_zero
);

   localparam int CW = $clog2(N) + 1;

   state_t         state;
   op_t            opr;
   logic [N-1:0]   hi;
   logic [N-1:0]   lo;
   logic [N-1:0]   dvsr;
   logic [2*N-1:0] acc;
   logic [CW-1:0]  cnt;
   logic           neg_q;
   logic           neg_r;

   logic            is_sgn;
   logic            is_div;
   logic [MAXW-1:0] a_m64;
   logic [MAXW-1:0] b_m64;
   logic [MAXW-1:0] p64;
   logic [MAXW-1:0] q64;
   logic [MAXW-1:0] r64;
   logic [N-1:0]    a_mag;
   logic [N-1:0]    b_mag;
   logic [N:0]      add_s;
   logic [N:0]      sub_c;
   logic [N:0]      sub_d;
   logic [N-1:0]    fix_hi;
   logic [N-1:0]    fix_lo;
   logic            unused_bits;

   always_comb begin
      is_sgn = ~op[0];
      is_div = op[1];
      a_m64  = mag_w(MAXW'(a), N, is_sgn);
      b_m64  = mag_w(MAXW'(b), N, is_sgn);
      a_mag  = a_m64[N-1:0];
      b_mag  = b_m64[N-1:0];
      add_s  = {1'b0, acc[2*N-1:N]}
             + (acc[0] ? {1'b0, dvsr} : '0);
      sub_c  = acc[2*N-1:N-1];
      sub_d  = sub_c - {1'b0, dvsr};
      p64 = MAXW'(acc);
      if (neg_q) p64 = neg_w(MAXW'(acc), 2 * N);
      q64 = MAXW'(acc[N-1:0]);
      if (neg_q) q64 = neg_w(q64, N);
      r64 = MAXW'(acc[2*N-1:N]);
      if (neg_r) r64 = neg_w(r64, N);
      fix_hi = p64[2*N-1:N];
      fix_lo = p64[N-1:0];
      if (opr == OP_DIV || opr == OP_DIVU) begin
         // on divide-by-zero acc holds the raw dividend
         if (div_zero) begin
            fix_hi = acc[N-1:0];
            fix_lo = '1;
         end else begin
            fix_hi = r64[N-1:0];
            fix_lo = q64[N-1:0];
         end
      end
   end

   assign unused_bits = ^{a_m64[MAXW-1:N], b_m64[MAXW-1:N],
                          q64[MAXW-1:N], r64[MAXW-1:N]};

   assign rdata = rd_hi ? hi : lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         opr      <= OP_MULT;
         hi       <= '0;
         lo       <= '0;
         dvsr     <= '0;
         acc      <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  opr      <= op_t'(op);
                  cnt      <= '0;
                  busy     <= 1'b1;
                  dvsr     <= b_mag;
                  neg_q    <= is_sgn & (a[N-1] ^ b[N-1]);
                  neg_r    <= is_sgn & a[N-1];
                  div_zero <= 1'b0;
                  acc      <= {{N{1'b0}}, a_mag};
                  if (is_div && b == '0) begin
                     div_zero <= 1'b1;
                     acc      <= {{N{1'b0}}, a};
                     state    <= FIX;
                  end else if (is_div) begin
                     state <= DIV;
                  end else begin
                     state <= MUL;
                  end
               end else begin
                  if (wr_hi) hi <= wdata;
                  if (wr_lo) lo <= wdata;
               end
            end
            MUL: begin
               acc <= {add_s, acc[N-1:1]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) state <= FIX;
            end
            DIV: begin
               acc <= {sub_d[N] ? sub_c[N-1:0] : sub_d[N-1:0],
                       acc[N-2:0], ~sub_d[N]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) state <= FIX;
            end
            FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops
// against a behavioural model, and hand sequences for corner cases.
module tb_muldiv_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wdata = '0;
   logic        rd_hi = 1'b0;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        div_zero;

   int   total = 0;
   int   passed = 0;
   exp_t sb[$];
   vec_t tbl[10];

   muldiv_unit #(.N(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .op(op),
      .a(a),
      .b(b),
      .wr_hi(wr_hi),
      .wr_lo(wr_lo),
      .wdata(wdata),
      .rd_hi(rd_hi),
      .rdata(rdata),
      .busy(busy),
      .done(done),
      .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, req);
   endtask

   function automatic exp_t model(input logic [1:0] o,
                                  input logic [31:0] x,
                                  input logic [31:0] y);
      exp_t   r;
      int     sx;
      int     sy;
      longint p;
      r.dz = 1'b0;
      sx = x;
      sy = y;
      case (o)
         2'b00: begin
            p = longint'(sx) * longint'(sy);
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         2'b01: begin
            p = {32'b0, x} * {32'b0, y};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         2'b10: begin
            if (y == 0) begin
               r.dz = 1'b1; r.hi = x; r.lo = '1;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               r.hi = 0; r.lo = 32'h8000_0000;
            end else begin
               r.lo = sx / sy;
               r.hi = sx % sy;
            end
         end
         default: begin
            if (y == 0) begin
               r.dz = 1'b1; r.hi = x; r.lo = '1;
            end else begin
               r.lo = x / y;
               r.hi = x % y;
            end
         end
      endcase
      return r;
   endfunction

   task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input exp_t e,
                        input int intr);
      logic [31:0] oh;
      logic [31:0] ol;
      int   k;
      int   nb;
      int   lat;
      bit   stale;
      bit   got;
      exp_t g;
      lat = e.dz ? 1 : 33;
      rd_hi = 1'b1; #1 oh = rdata;
      rd_hi = 1'b0; #1 ol = rdata;
      sb.push_back(e);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_e0", 32'(busy), 32'd1);
      check("dz_e0", 32'(div_zero), 32'(e.dz));
      k = 0; nb = 1; stale = 0; got = 0;
      while (!got && k < 100) begin
         if (k == intr) begin
            op = ~o; a = ~x; b = 32'd3; start = 1'b1;
            wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
         end
         rd_hi = 1'b1; #1 if (rdata !== oh) stale = 1;
         rd_hi = 1'b0; #1 if (rdata !== ol) stale = 1;
         @(posedge clk); #1 start = 1'b0; wr_hi = 1'b0;
         k++;
         if (done) got = 1;
         else if (busy) nb++;
      end
      check("done_seen", 32'(got), 32'd1);
      check("latency", 32'(k), 32'(lat));
      check("busy_cycles", 32'(nb), 32'(lat));
      check("busy_at_done", 32'(busy), 32'd0);
      check("stale_rdata", 32'(stale), 32'd0);
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'(sb.size()));
      end else begin
         g = sb.pop_front();
         rd_hi = 1'b1; #1 check("hi", rdata, g.hi);
         rd_hi = 1'b0; #1 check("lo", rdata, g.lo);
         check("div_zero", 32'(div_zero), 32'(g.dz));
      end
   endtask

   initial begin
      exp_t        e;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;

      tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,
                 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h0000_0000, 32'h8000_0000, 1'b0};
      tbl[4] = '{2'b11, 32'd100, 32'd7,
                 32'd2, 32'd14, 1'b0};
      tbl[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000,
                 32'h4000_0000, 32'h0000_0000, 1'b0};
      tbl[6] = '{2'b10, 32'd7, 32'hFFFF_FFFE,
                 32'd1, 32'hFFFF_FFFD, 1'b0};
      tbl[7] = '{2'b01, 32'h0001_0000, 32'h0001_0000,
                 32'd1, 32'd0, 1'b0};
      tbl[8] = '{2'b11, 32'd100, 32'd0,
                 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
      tbl[9] = '{2'b01, 32'd3, 32'd4,
                 32'd0, 32'd12, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dz", 32'(div_zero), 32'd0);
      rd_hi = 1'b1; #1 check("rst_hi", rdata, 32'd0);
      rd_hi = 1'b0; #1 check("rst_lo", rdata, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      wr_hi = 1'b1; wdata = 32'hAAAA_5555;
      @(posedge clk); #1 wr_hi = 1'b0;
      rd_hi = 1'b1; #1 check("mthi", rdata, 32'hAAAA_5555);
      wr_lo = 1'b1; wdata = 32'h5555_AAAA;
      @(posedge clk); #1 wr_lo = 1'b0;
      rd_hi = 1'b0; #1 check("mtlo", rdata, 32'h5555_AAAA);
      rd_hi = 1'b1; #1 check("mtlo_keep_hi", rdata, 32'hAAAA_5555);
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234_5678;
      @(posedge clk); #1 wr_hi = 1'b0; wr_lo = 1'b0;
      rd_hi = 1'b1; #1 check("mtboth_hi", rdata, 32'h1234_5678);
      rd_hi = 1'b0; #1 check("mtboth_lo", rdata, 32'h1234_5678);

      // start plus mthi mid-operation must both be dropped
      e = '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      do_op(2'b00, 32'hFFFF_FFFD, 32'd5, e, 10);
      @(posedge clk); #1 check("done_pulse", 32'(done), 32'd0);

      for (int i = 0; i < 10; i++) begin
         e = '{tbl[i].hi, tbl[i].lo, tbl[i].dz};
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, e, -1);
      end

      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : $urandom;
         if (i == 2) rb = rb >> 20;
         do_op(ro, ra, rb, model(ro, ra, rb), -1);
      end

      op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_dz", 32'(div_zero), 32'd0);
      rd_hi = 1'b1; #1 check("arst_hi", rdata, 32'd0);
      rd_hi = 1'b0; #1 check("arst_lo", rdata, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      e = '{32'd0, 32'd42, 1'b0};
      do_op(2'b01, 32'd7, 32'd6, e, -1);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
